// File: rtl/telemetry_pkg.sv
// rtl/telemetry_pkg.sv - shared types, constants and checksum helper for the telemetry scheduler
package telemetry_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ID   = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    GAP  = 3'd5
  } state_t;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam int         ID_W         = 3;

  function automatic logic [7:0] frame_csum(input logic [7:0]      hdr,
                                            input logic [ID_W-1:0] id,
                                            input logic [7:0]      data);
    return hdr ^ {{(8-ID_W){1'b0}}, id} ^ data;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant; the caller owns the pointer register
module rr_arbiter
  import telemetry_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               any_req_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic [NUM_REQ-1:0] grant_oh_o
);

  int   idx;
  logic found;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    any_req_o   = |req_i;
    grant_idx_o = '0;
    grant_oh_o  = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found           = 1'b1;
        grant_idx_o     = ID_W'(idx);
        grant_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/telemetry_tx_scheduler.sv
// rtl/telemetry_tx_scheduler.sv - round-robin framer sharing one uart_tx between status producers
module telemetry_tx_scheduler
  import telemetry_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter logic [7:0] HEADER     = FRAME_HEADER,
  parameter int         GAP_CYCLES = 1000,
  parameter int         TX_TIMEOUT = 62500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_byte,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam state_t END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t               state_q;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      grant_q;
  logic [7:0]           payload_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic                 tx_valid_q;
  logic [7:0]           tx_byte_q;
  logic                 frame_done_q;
  logic                 frame_abort_q;

  logic                 any_req;
  logic [ID_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]   grant_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .any_req_o   (any_req),
    .grant_idx_o (grant_idx),
    .grant_oh_o  (grant_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      grant_q       <= '0;
      payload_q     <= '0;
      gap_cnt_q     <= '0;
      to_cnt_q      <= '0;
      req_ready_q   <= '0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      req_ready_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q     <= grant_idx;
            ptr_q       <= grant_idx;
            payload_q   <= req_data[8*int'(grant_idx) +: 8];
            req_ready_q <= grant_oh;
            tx_byte_q   <= HEADER;
            tx_valid_q  <= 1'b1;
            to_cnt_q    <= '0;
            state_q     <= HDR;
          end
        end
        // tx_valid is always high in these states, so tx_ready alone means accept.
        HDR, ID, DATA, CSUM: begin
          if (tx_ready) begin
            to_cnt_q <= '0;
            case (state_q)
              HDR: begin
                tx_byte_q <= {{(8-ID_W){1'b0}}, grant_q};
                state_q   <= ID;
              end
              ID: begin
                tx_byte_q <= payload_q;
                state_q   <= DATA;
              end
              DATA: begin
                tx_byte_q <= frame_csum(HEADER, grant_q, payload_q);
                state_q   <= CSUM;
              end
              default: begin
                tx_valid_q   <= 1'b0;
                frame_done_q <= 1'b1;
                gap_cnt_q    <= '0;
                state_q      <= END_STATE;
              end
            endcase
          end else if (to_cnt_q == TO_W'(TX_TIMEOUT - 1)) begin
            tx_valid_q    <= 1'b0;
            frame_abort_q <= 1'b1;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            state_q       <= END_STATE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
            gap_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_byte     = tx_byte_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_telemetry_tx_scheduler.sv
// tb/tb_telemetry_tx_scheduler.sv - directed self-checking bench for telemetry_tx_scheduler
module tb_telemetry_tx_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;

  logic [3:0] req_ready_a, req_ready_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_ready_a, tx_ready_b;
  logic [7:0] tx_byte_a, tx_byte_b;
  logic [2:0] grant_id_a, grant_id_b;
  logic       busy_a, busy_b;
  logic       frame_done_a, frame_done_b;
  logic       frame_abort_a, frame_abort_b;

  telemetry_tx_scheduler #(
    .NUM_REQ(4), .HEADER(8'hA5), .GAP_CYCLES(4), .TX_TIMEOUT(1000)
  ) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .tx_byte(tx_byte_a), .grant_id(grant_id_a), .busy(busy_a),
    .frame_done(frame_done_a), .frame_abort(frame_abort_a)
  );

  telemetry_tx_scheduler #(
    .NUM_REQ(4), .HEADER(8'hA5), .GAP_CYCLES(4), .TX_TIMEOUT(100)
  ) u_dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .tx_byte(tx_byte_b), .grant_id(grant_id_b), .busy(busy_b),
    .frame_done(frame_done_b), .frame_abort(frame_abort_b)
  );

  bit         sel_b = 1'b0;
  logic [3:0] m_req_ready;
  logic       m_tx_valid, m_busy, m_frame_done, m_frame_abort;
  logic [7:0] m_tx_byte;
  logic [2:0] m_grant_id;

  always_comb begin
    m_req_ready   = sel_b ? req_ready_b   : req_ready_a;
    m_tx_valid    = sel_b ? tx_valid_b    : tx_valid_a;
    m_busy        = sel_b ? busy_b        : busy_a;
    m_frame_done  = sel_b ? frame_done_b  : frame_done_a;
    m_frame_abort = sel_b ? frame_abort_b : frame_abort_a;
    m_tx_byte     = sel_b ? tx_byte_b     : tx_byte_a;
    m_grant_id    = sel_b ? grant_id_b    : grant_id_a;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] t3_exp [4] = '{8'hA5, 8'h00, 8'h5A, 8'hFF};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Returns after the grant edge; gap counts busy-but-silent cycles seen while waiting.
  task automatic wait_grant(output int gap, output bit prev_idle);
    bit prev_busy;
    bit seen;
    gap       = 0;
    seen      = 1'b0;
    prev_busy = m_busy;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (m_busy && !m_tx_valid) gap++;
      prev_busy = m_busy;
      tick;
      if (|m_req_ready) seen = 1'b1;
    end
    check_eq("grant_seen", {31'd0, seen}, 32'd1);
    prev_idle = !prev_busy;
  endtask

  task automatic expect_frame(input string tag, input logic [2:0] id,
                              input logic [7:0] pl, input logic [7:0] cs);
    check_eq({tag, "_grant_id"}, {29'd0, m_grant_id}, {29'd0, id});
    check_eq({tag, "_hdr"}, {23'd0, m_tx_valid, m_tx_byte}, {23'd0, 1'b1, 8'hA5});
    tick;
    check_eq({tag, "_ready_once"}, {28'd0, m_req_ready}, 32'd0);
    check_eq({tag, "_id"}, {23'd0, m_tx_valid, m_tx_byte}, {23'd0, 1'b1, 5'd0, id});
    tick;
    check_eq({tag, "_data"}, {23'd0, m_tx_valid, m_tx_byte}, {23'd0, 1'b1, pl});
    tick;
    check_eq({tag, "_csum"}, {22'd0, m_frame_done, m_tx_valid, m_tx_byte}, {22'd0, 1'b0, 1'b1, cs});
    tick;
    check_eq({tag, "_done"}, {30'd0, m_tx_valid, m_frame_done}, 32'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         gap;
    bit         pidle;
    bit         stable;
    bit         seen;
    bit         saw_done;
    int         n;
    int         extra;
    logic [3:0] exp_oh;
    logic [7:0] t2_cs [4];

    t2_cs = '{8'hB5, 8'h84, 8'h97, 8'hE6};
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    tx_ready_a = 1'b1;
    tx_ready_b = 1'b1;
    do_reset;

    check_eq("rst_tx_valid", {31'd0, m_tx_valid}, 32'd0);
    check_eq("rst_req_ready", {28'd0, m_req_ready}, 32'd0);
    check_eq("rst_tx_byte", {24'd0, m_tx_byte}, 32'd0);
    check_eq("rst_grant_id", {29'd0, m_grant_id}, 32'd0);
    check_eq("rst_busy", {31'd0, m_busy}, 32'd0);
    check_eq("rst_pulses", {30'd0, m_frame_done, m_frame_abort}, 32'd0);

    // Single requester 2, full-speed transmitter.
    req_data[23:16] = 8'h3C;
    req_valid       = 4'b0100;
    tick;
    check_eq("t1_req_ready", {28'd0, m_req_ready}, 32'b0100);
    req_valid = '0;
    expect_frame("t1", 3'd2, 8'h3C, 8'h9B);

    // All four requesters held valid: strict rotation 0,1,2,3,0.
    do_reset;
    req_data  = {8'h40, 8'h30, 8'h20, 8'h10};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(gap, pidle);
      exp_oh = 4'b0001 << (k % 4);
      check_eq($sformatf("t2_ready_%0d", k), {28'd0, m_req_ready}, {28'd0, exp_oh});
      check_eq($sformatf("t2_gap_%0d", k), gap, (k == 0) ? 0 : 4);
      check_eq($sformatf("t2_from_idle_%0d", k), {31'd0, pidle}, 32'd1);
      expect_frame($sformatf("t2_f%0d", k), 3'(k % 4), 8'((k % 4 + 1) * 16), t2_cs[k % 4]);
    end
    req_valid = '0;

    // Backpressure: 500 stalled cycles on every byte.
    do_reset;
    req_data[7:0] = 8'h5A;
    req_valid     = 4'b0001;
    tx_ready_a    = 1'b0;
    wait_grant(gap, pidle);
    req_valid = '0;
    check_eq("t3_grant", {29'd0, m_grant_id}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      stable = 1'b1;
      for (int c = 0; c < 500; c++) begin
        if (!(m_tx_valid && m_tx_byte == t3_exp[b] && !m_frame_abort)) stable = 1'b0;
        tick;
      end
      check_eq($sformatf("t3_stable_b%0d", b), {31'd0, stable}, 32'd1);
      check_eq($sformatf("t3_byte_b%0d", b), {24'd0, m_tx_byte}, {24'd0, t3_exp[b]});
      tx_ready_a = 1'b1;
      tick;
      tx_ready_a = 1'b0;
    end
    check_eq("t3_done", {30'd0, m_tx_valid, m_frame_done}, 32'b01);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (m_frame_done || m_tx_valid || m_frame_abort) extra++;
    end
    check_eq("t3_single_frame", extra, 0);

    // Transmitter stuck: abort after 100 cycles, pointer stays advanced.
    tx_ready_a = 1'b1;
    sel_b      = 1'b1;
    tx_ready_b = 1'b0;
    do_reset;
    req_data[7:0]  = 8'h21;
    req_data[15:8] = 8'h22;
    req_valid      = 4'b0011;
    wait_grant(gap, pidle);
    check_eq("t4_first_grant", {28'd0, m_req_ready}, 32'b0001);
    seen     = 1'b0;
    saw_done = 1'b0;
    n        = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick;
      n++;
      if (m_frame_abort) seen = 1'b1;
      if (m_frame_done) saw_done = 1'b1;
    end
    check_eq("t4_abort_cycle", n, 100);
    check_eq("t4_abort_state", {30'd0, m_tx_valid, m_busy}, 32'b01);
    check_eq("t4_no_done", {31'd0, saw_done}, 32'd0);
    tx_ready_b = 1'b1;
    wait_grant(gap, pidle);
    check_eq("t4_next_ready", {28'd0, m_req_ready}, 32'b0010);
    check_eq("t4_gap", gap, 4);
    expect_frame("t4_next", 3'd1, 8'h22, 8'h86);
    req_valid = '0;
    sel_b     = 1'b0;

    // Reset in the middle of the DATA byte.
    do_reset;
    req_data[23:16] = 8'h5C;
    req_valid       = 4'b0100;
    wait_grant(gap, pidle);
    req_valid = '0;
    check_eq("t5_grant", {29'd0, m_grant_id}, 32'd2);
    tick;
    tick;
    check_eq("t5_in_data", {23'd0, m_tx_valid, m_tx_byte}, {23'd0, 1'b1, 8'h5C});
    rst           = 1'b1;
    req_valid     = 4'b1001;
    req_data[7:0] = 8'h11;
    tick;
    check_eq("t5_rst_outputs", {27'd0, m_tx_valid, m_busy, m_frame_done, m_frame_abort, |m_req_ready}, 32'd0);
    rst = 1'b0;
    wait_grant(gap, pidle);
    check_eq("t5_req0_first", {28'd0, m_req_ready}, 32'b0001);
    req_valid = '0;
    expect_frame("t5_after", 3'd0, 8'h11, 8'hB4);

    // Single persistent requester 1.
    do_reset;
    req_data[15:8] = 8'h77;
    req_valid      = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      wait_grant(gap, pidle);
      check_eq($sformatf("t6_ready_%0d", k), {28'd0, m_req_ready}, 32'b0010);
      check_eq($sformatf("t6_from_idle_%0d", k), {31'd0, pidle}, 32'd1);
      check_eq($sformatf("t6_gap_%0d", k), gap, (k == 0) ? 0 : 4);
      expect_frame($sformatf("t6_f%0d", k), 3'd1, 8'h77, 8'hD3);
    end
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
